// File: rtl/noc_pkg.sv
// Shared types and defaults for the port request generator: FSM state encoding,
// port index type, the timeout default and the destination legality check.
package noc_pkg;

    localparam int MAX_PORTS              = 16;
    localparam int PORT_IDX_W             = $clog2(MAX_PORTS);
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    // A destination is legal if it exists and is not the generator's own port.
    function automatic logic is_legal_dst(input port_idx_t dst, input int num_ports,
                                          input int location);
        return (int'(dst) != location) && (int'(dst) < num_ports);
    endfunction

endpackage

// File: rtl/port_request_generator_if.sv
// Flit handshake and 2-phase downstream request/acknowledge bundle.
// Signal suffixes are from the generator's point of view (slave modport).
interface port_request_generator_if #(
    parameter int NUM_PORTS = 4
);
    localparam int DST_W = $clog2(NUM_PORTS);

    logic                 flit_valid_i;
    logic                 flit_ready_o;
    logic                 flit_head_i;
    logic                 flit_tail_i;
    logic [DST_W-1:0]     flit_dst_i;
    logic [NUM_PORTS-1:0] req_dw_o;
    logic [NUM_PORTS-1:0] ack_dw_i;
    logic [NUM_PORTS-1:0] packet_enable_o;
    logic                 err_o;
    logic                 timeout_o;

    modport slave (
        input  flit_valid_i, flit_head_i, flit_tail_i, flit_dst_i, ack_dw_i,
        output flit_ready_o, req_dw_o, packet_enable_o, err_o, timeout_o
    );

    modport master (
        output flit_valid_i, flit_head_i, flit_tail_i, flit_dst_i, ack_dw_i,
        input  flit_ready_o, req_dw_o, packet_enable_o, err_o, timeout_o
    );

endinterface

// File: rtl/ack_synchronizer.sv
// Multi-flop synchronizer bringing the asynchronous 2-phase ack lines into clk_i.
// Each bit gets its own STAGES-deep chain; the last stage is the synchronized value.
module ack_synchronizer #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    // NOTE: the chain is reset like any other flop so a released reset never shows
    // a spurious ack phase to the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/port_request_generator.sv
// Forwards upstream flits as 2-phase request toggles to one locked downstream port,
// holding the lock from head to tail and waiting for each flit's ack before the next.
module port_request_generator
    import noc_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int LOCATION       = 0,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    port_request_generator_if.slave bus
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e               state_q;
    port_idx_t            dst_q;
    logic                 tail_q;
    logic [NUM_PORTS-1:0] req_q;
    logic [NUM_PORTS-1:0] enable_q;
    logic                 err_q;
    logic                 timeout_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    logic [NUM_PORTS-1:0] ack_sync;
    logic [NUM_PORTS-1:0] head_oh;
    logic [NUM_PORTS-1:0] dst_oh;
    port_idx_t            head_dst;
    logic                 head_legal;
    logic                 ack_done;

    ack_synchronizer #(
        .WIDTH (NUM_PORTS),
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (bus.ack_dw_i),
        .q_o   (ack_sync)
    );

    assign head_dst   = port_idx_t'(bus.flit_dst_i);
    assign head_legal = is_legal_dst(head_dst, NUM_PORTS, LOCATION);

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block
        // leaves it unassigned and infers a latch.
        head_oh = '0;
        dst_oh  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            head_oh[p] = (head_dst == port_idx_t'(p));
            dst_oh[p]  = (dst_q == port_idx_t'(p));
        end
        cnt_d = cnt_q;
        if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The flit is complete once the returned ack phase on the locked port matches its request phase.
    assign ack_done = ~|((ack_sync ^ req_q) & dst_oh);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            dst_q     <= '0;
            tail_q    <= 1'b0;
            req_q     <= '0;
            enable_q  <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.flit_valid_i) begin
                        if (bus.flit_head_i && head_legal) begin
                            req_q    <= req_q ^ head_oh;
                            enable_q <= head_oh;
                            dst_q    <= head_dst;
                            tail_q   <= bus.flit_tail_i;
                            cnt_q    <= '0;
                            state_q  <= ST_WAIT_ACK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    cnt_q <= cnt_d;
                    if (TIMEOUT_EN && (cnt_d == CNT_LIMIT)) begin
                        timeout_q <= 1'b1;
                    end
                    if (ack_done) begin
                        if (tail_q) begin
                            enable_q <= '0;
                            state_q  <= ST_IDLE;
                        end else begin
                            state_q <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.flit_valid_i) begin
                        if (bus.flit_head_i) begin
                            err_q <= 1'b1;
                        end else begin
                            req_q   <= req_q ^ dst_oh;
                            tail_q  <= bus.flit_tail_i;
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_ACK;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.flit_ready_o    = (state_q != ST_WAIT_ACK);
    assign bus.req_dw_o        = req_q;
    assign bus.packet_enable_o = enable_q;
    assign bus.err_o           = err_q;
    assign bus.timeout_o       = timeout_q;

endmodule

// File: tb/tb_port_request_generator.sv
// Scoreboard bench: each forwarded flit queues its expected port; a negedge monitor
// pops the queue on every observed req_dw_o change and compares the toggled bit.
module tb_port_request_generator;

    localparam int NP  = 4;
    localparam int LOC = 0;
    localparam int SS  = 2;
    localparam int TO  = 8;
    localparam int DW  = $clog2(NP);

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    port_request_generator_if #(.NUM_PORTS(NP)) bus ();

    port_request_generator #(
        .NUM_PORTS     (NP),
        .LOCATION      (LOC),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int            total = 0;
    int            bad   = 0;
    int            exp_q[$];
    logic [NP-1:0] req_exp  = '0;
    logic [NP-1:0] prev_req = '0;
    logic          mon_en   = 1'b0;

    function automatic logic [NP-1:0] oh(input int p);
        return NP'(1) << p;
    endfunction

    // Request-toggle monitor: any change of req_dw_o must be exactly the next queued port.
    always @(negedge clk_i) begin
        if (!mon_en) begin
            prev_req = bus.req_dw_o;
        end else if (bus.req_dw_o !== prev_req) begin
            logic [NP-1:0] diff;
            int            port;
            diff = bus.req_dw_o ^ prev_req;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL req_toggle: unexpected toggle mask %b, none expected", diff);
            end else begin
                port = exp_q.pop_front();
                if (diff !== oh(port)) begin
                    bad++;
                    $display("FAIL req_toggle: toggle mask %b, expected %b", diff, oh(port));
                end
            end
            prev_req = bus.req_dw_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive_flit(input logic head, input logic tail, input int dst);
        bus.flit_valid_i = 1'b1;
        bus.flit_head_i  = head;
        bus.flit_tail_i  = tail;
        bus.flit_dst_i   = DW'(dst);
        tick(1);
        bus.flit_valid_i = 1'b0;
        bus.flit_head_i  = 1'b0;
        bus.flit_tail_i  = 1'b0;
    endtask

    // Forward one flit to dst, return its ack at once and check the exact ack-to-ready latency.
    task automatic send_and_ack(input logic head, input logic tail, input int dst, input string tag);
        logic [NP-1:0] en_exp;
        en_exp = oh(dst);
        exp_q.push_back(dst);
        req_exp ^= oh(dst);
        drive_flit(head, tail, dst);
        total++; if (bus.req_dw_o !== req_exp) begin bad++; $display("FAIL %s req_dw: got %b want %b", tag, bus.req_dw_o, req_exp); end
        total++; if (bus.flit_ready_o !== 1'b0) begin bad++; $display("FAIL %s ready_in_wait: got %b want 0", tag, bus.flit_ready_o); end
        total++; if (bus.packet_enable_o !== en_exp) begin bad++; $display("FAIL %s enable_in_wait: got %b want %b", tag, bus.packet_enable_o, en_exp); end
        bus.ack_dw_i[dst] = ~bus.ack_dw_i[dst];
        for (int i = 1; i <= SS + 1; i++) begin
            tick(1);
            total++;
            if (bus.flit_ready_o !== (i == SS + 1)) begin
                bad++; $display("FAIL %s ack_latency edge %0d: ready got %b want %b", tag, i, bus.flit_ready_o, (i == SS + 1));
            end
        end
        total++;
        if (bus.packet_enable_o !== (tail ? {NP{1'b0}} : en_exp)) begin
            bad++; $display("FAIL %s enable_after_ack: got %b want %b", tag, bus.packet_enable_o, (tail ? {NP{1'b0}} : en_exp));
        end
    endtask

    task automatic test_reset();
        bus.flit_valid_i = 1'b0; bus.flit_head_i = 1'b0; bus.flit_tail_i = 1'b0;
        bus.flit_dst_i = '0; bus.ack_dw_i = '0;
        tick(3);
        total++; if (bus.req_dw_o !== 4'b0000) begin bad++; $display("FAIL reset req_dw: got %b want 0000", bus.req_dw_o); end
        total++; if (bus.packet_enable_o !== 4'b0000) begin bad++; $display("FAIL reset enable: got %b want 0000", bus.packet_enable_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", bus.err_o); end
        total++; if (bus.timeout_o !== 1'b0) begin bad++; $display("FAIL reset timeout: got %b want 0", bus.timeout_o); end
        rst_ni = 1'b1;
        tick(1);
        mon_en = 1'b1;
        total++; if (bus.flit_ready_o !== 1'b1) begin bad++; $display("FAIL reset ready_idle: got %b want 1", bus.flit_ready_o); end
    endtask

    task automatic test_single_flit();
        send_and_ack(1'b1, 1'b1, 2, "single");
    endtask

    task automatic test_multi_flit();
        send_and_ack(1'b1, 1'b0, 3, "multi_head");
        send_and_ack(1'b0, 1'b0, 3, "multi_body");
        send_and_ack(1'b0, 1'b1, 3, "multi_tail");
    endtask

    task automatic test_illegal_dst();
        drive_flit(1'b1, 1'b1, LOC);
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL own_dst err: got %b want 1", bus.err_o); end
        total++; if (bus.req_dw_o !== req_exp) begin bad++; $display("FAIL own_dst req_dw: got %b want %b", bus.req_dw_o, req_exp); end
        total++; if (bus.flit_ready_o !== 1'b1) begin bad++; $display("FAIL own_dst ready: got %b want 1", bus.flit_ready_o); end
        tick(1);
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL own_dst err_pulse_width: got %b want 0", bus.err_o); end
        drive_flit(1'b0, 1'b1, 1);
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL idle_body err: got %b want 1", bus.err_o); end
        total++; if (bus.packet_enable_o !== 4'b0000) begin bad++; $display("FAIL idle_body enable: got %b want 0000", bus.packet_enable_o); end
        tick(1);
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL idle_body err_pulse_width: got %b want 0", bus.err_o); end
    endtask

    task automatic test_head_in_locked();
        send_and_ack(1'b1, 1'b0, 1, "lock_head");
        drive_flit(1'b1, 1'b1, 2);
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL locked_head err: got %b want 1", bus.err_o); end
        total++; if (bus.flit_ready_o !== 1'b1) begin bad++; $display("FAIL locked_head ready: got %b want 1", bus.flit_ready_o); end
        total++; if (bus.packet_enable_o !== 4'b0010) begin bad++; $display("FAIL locked_head enable: got %b want 0010", bus.packet_enable_o); end
        tick(1);
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL locked_head err_pulse_width: got %b want 0", bus.err_o); end
        send_and_ack(1'b0, 1'b1, 1, "lock_tail");
    endtask

    task automatic test_ignore_other_ack();
        exp_q.push_back(2);
        req_exp ^= oh(2);
        drive_flit(1'b1, 1'b1, 2);
        bus.ack_dw_i[1] = ~bus.ack_dw_i[1];
        for (int i = 0; i < 3; i++) begin
            tick(1);
            total++; if (bus.flit_ready_o !== 1'b0) begin bad++; $display("FAIL other_ack ready cycle %0d: got %b want 0", i, bus.flit_ready_o); end
            total++; if (bus.packet_enable_o !== 4'b0100) begin bad++; $display("FAIL other_ack enable cycle %0d: got %b want 0100", i, bus.packet_enable_o); end
        end
        bus.ack_dw_i[2] = ~bus.ack_dw_i[2];
        tick(SS);
        total++; if (bus.flit_ready_o !== 1'b0) begin bad++; $display("FAIL other_ack early_exit: ready got %b want 0", bus.flit_ready_o); end
        tick(1);
        total++; if (bus.flit_ready_o !== 1'b1) begin bad++; $display("FAIL other_ack completion: ready got %b want 1", bus.flit_ready_o); end
        total++; if (bus.packet_enable_o !== 4'b0000) begin bad++; $display("FAIL other_ack enable_cleared: got %b want 0000", bus.packet_enable_o); end
        bus.ack_dw_i[1] = ~bus.ack_dw_i[1];
        tick(SS + 1);
    endtask

    task automatic test_timeout();
        exp_q.push_back(3);
        req_exp ^= oh(3);
        drive_flit(1'b1, 1'b1, 3);
        for (int i = 1; i <= TO; i++) begin
            tick(1);
            total++;
            if (bus.timeout_o !== (i >= TO)) begin
                bad++; $display("FAIL timeout wait_cycle %0d: got %b want %b", i, bus.timeout_o, (i >= TO));
            end
        end
        total++; if (bus.flit_ready_o !== 1'b0) begin bad++; $display("FAIL timeout keeps_waiting: ready got %b want 0", bus.flit_ready_o); end
        bus.ack_dw_i[3] = ~bus.ack_dw_i[3];
        tick(SS + 1);
        total++; if (bus.flit_ready_o !== 1'b1) begin bad++; $display("FAIL timeout late_ack: ready got %b want 1", bus.flit_ready_o); end
        tick(4);
        total++; if (bus.timeout_o !== 1'b1) begin bad++; $display("FAIL timeout sticky: got %b want 1", bus.timeout_o); end
    endtask

    task automatic test_reset_locked();
        send_and_ack(1'b1, 1'b0, 2, "rst_head");
        mon_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        total++; if (bus.req_dw_o !== 4'b0000) begin bad++; $display("FAIL rst_locked req_dw: got %b want 0000", bus.req_dw_o); end
        total++; if (bus.packet_enable_o !== 4'b0000) begin bad++; $display("FAIL rst_locked enable: got %b want 0000", bus.packet_enable_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL rst_locked err: got %b want 0", bus.err_o); end
        total++; if (bus.timeout_o !== 1'b0) begin bad++; $display("FAIL rst_locked timeout: got %b want 0", bus.timeout_o); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_locked pending: got %0d want 0", exp_q.size()); end
        bus.ack_dw_i = '0;
        req_exp = '0;
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        mon_en = 1'b1;
        total++; if (bus.flit_ready_o !== 1'b1) begin bad++; $display("FAIL rst_locked ready_idle: got %b want 1", bus.flit_ready_o); end
        send_and_ack(1'b1, 1'b1, 1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_multi_flit();
        test_illegal_dst();
        test_head_in_locked();
        test_ignore_other_ack();
        test_timeout();
        test_reset_locked();
        tick(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain: %0d forwarded flits never seen, want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
